// File: rtl/next_pc_unit.sv
// Registered PC sequencer: CBZ/CBNZ/unconditional redirect, stall hold, RUN/HALT FSM
// and saturating taken-branch counter. Define PC_ALIGN_CHECK_EN to add the Misaligned trap.
module next_pc_unit #(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          INSTR_BYTES = 4,
  parameter int unsigned          IMM_SHIFT   = 2,
  parameter int unsigned          CNT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 resetl,
  input  logic [PC_WIDTH-1:0]  SignExtImm64,
  input  logic                 Branch,
  input  logic                 BranchNZ,
  input  logic                 Uncondbranch,
  input  logic                 ALUZero,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 Resume,
  output logic [PC_WIDTH-1:0]  CurrentPC,
  output logic [PC_WIDTH-1:0]  NextPC,
  output logic                 Taken,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] BranchCount
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                 Misaligned
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t               state, state_nxt;
  logic [PC_WIDTH-1:0]  seq, tgt, pc_nxt;
  logic                 take, bad_align;
  logic                 taken_nxt, halted_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  assign take = Uncondbranch | (Branch & ALUZero) | (BranchNZ & ~ALUZero);
  assign seq  = CurrentPC + PC_WIDTH'(INSTR_BYTES);
  assign tgt  = CurrentPC + (SignExtImm64 << IMM_SHIFT);

  always_comb begin
    NextPC = CurrentPC;
    if (state == RUN) NextPC = take ? tgt : seq;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign bad_align = (NextPC % PC_WIDTH'(INSTR_BYTES)) != '0;
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    pc_nxt     = CurrentPC;
    taken_nxt  = 1'b0;
    halted_nxt = Halted;
    cnt_nxt    = BranchCount;
    case (state)
      RUN: begin
        if (bad_align) begin
          // Trap without committing the fetch address or counting the branch
          state_nxt  = HALT;
          halted_nxt = 1'b1;
        end else begin
          pc_nxt    = NextPC;
          taken_nxt = take;
          if (take && (BranchCount != '1)) cnt_nxt = BranchCount + 1'b1;
          if (Halt) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end
        end
      end
      HALT: begin
        if (Resume) begin
          state_nxt  = RUN;
          halted_nxt = 1'b0;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= RUN;
      CurrentPC   <= RESET_PC;
      Taken       <= 1'b0;
      Halted      <= 1'b0;
      BranchCount <= '0;
    end else if (!Stall) begin
      state       <= state_nxt;
      CurrentPC   <= pc_nxt;
      Taken       <= taken_nxt;
      Halted      <= halted_nxt;
      BranchCount <= cnt_nxt;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl)                               Misaligned <= 1'b0;
    else if (!Stall && state == RUN && bad_align) Misaligned <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (default build), plus a narrow-counter
// instance to exercise BranchCount saturation.
module tb_next_pc_unit;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] SignExtImm64;
  logic        Branch, BranchNZ, Uncondbranch, ALUZero, Stall, Halt, Resume;
  logic [63:0] CurrentPC, NextPC;
  logic        Taken, Halted;
  logic [31:0] BranchCount;

  logic [63:0] s_pc, s_npc;
  logic        s_taken, s_halted;
  logic [1:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  next_pc_unit dut (
    .CLK(CLK), .resetl(resetl), .SignExtImm64(SignExtImm64),
    .Branch(Branch), .BranchNZ(BranchNZ), .Uncondbranch(Uncondbranch),
    .ALUZero(ALUZero), .Stall(Stall), .Halt(Halt), .Resume(Resume),
    .CurrentPC(CurrentPC), .NextPC(NextPC), .Taken(Taken),
    .Halted(Halted), .BranchCount(BranchCount)
  );

  next_pc_unit #(.CNT_WIDTH(2)) dut_sat (
    .CLK(CLK), .resetl(resetl), .SignExtImm64(64'h1),
    .Branch(1'b0), .BranchNZ(1'b0), .Uncondbranch(1'b1),
    .ALUZero(1'b0), .Stall(1'b0), .Halt(1'b0), .Resume(1'b0),
    .CurrentPC(s_pc), .NextPC(s_npc), .Taken(s_taken),
    .Halted(s_halted), .BranchCount(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ctl(input logic b, input logic bnz, input logic u, input logic z,
                     input logic [63:0] imm);
    Branch = b; BranchNZ = bnz; Uncondbranch = u; ALUZero = z; SignExtImm64 = imm;
  endtask

  initial begin
    resetl = 1'b0; Stall = 1'b0; Halt = 1'b0; Resume = 1'b0;
    ctl(0, 0, 0, 0, 64'h0);
    #12;
    check("rst_pc", CurrentPC, 64'h0);
    check("rst_taken", {63'h0, Taken}, 64'h0);
    check("rst_halted", {63'h0, Halted}, 64'h0);
    check("rst_cnt", {32'h0, BranchCount}, 64'h0);
    check("rst_npc", NextPC, 64'h4);
    resetl = 1'b1;

    // sequential flow
    step(); check("seq_pc1", CurrentPC, 64'h4);
    step(); check("seq_pc2", CurrentPC, 64'h8);
    step(); check("seq_pc3", CurrentPC, 64'hC);
    check("seq_taken", {63'h0, Taken}, 64'h0);
    check("seq_cnt", {32'h0, BranchCount}, 64'h0);
    step(); check("seq_pc4", CurrentPC, 64'h10);

    // CBZ taken, then CBNZ not taken
    ctl(1, 0, 0, 1, 64'h3);
    #1 check("cbz_npc", NextPC, 64'h1C);
    step(); check("cbz_pc", CurrentPC, 64'h1C);
    check("cbz_taken", {63'h0, Taken}, 64'h1);
    check("cbz_cnt", {32'h0, BranchCount}, 64'h1);
    ctl(0, 1, 0, 1, 64'h3);
    step(); check("cbnz_nt_pc", CurrentPC, 64'h20);
    check("cbnz_nt_taken", {63'h0, Taken}, 64'h0);
    check("cbnz_nt_cnt", {32'h0, BranchCount}, 64'h1);

    // unconditional backward, then wrap
    ctl(0, 0, 0, 0, 64'h0);
    step(); check("pre_ub_pc", CurrentPC, 64'h24);
    ctl(0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); check("ub_back_pc", CurrentPC, 64'h20);
    ctl(0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF7);
    step(); check("ub_far_pc", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
    check("ub_far_cnt", {32'h0, BranchCount}, 64'h3);
    ctl(0, 0, 0, 0, 64'h0);
    step(); check("wrap_pc", CurrentPC, 64'h0);
    check("wrap_taken", {63'h0, Taken}, 64'h0);

    // CBNZ taken
    ctl(0, 1, 0, 0, 64'h2);
    step(); check("cbnz_t_pc", CurrentPC, 64'h8);
    check("cbnz_t_cnt", {32'h0, BranchCount}, 64'h4);

    // stall with redirect + halt pending
    Stall = 1'b1; Halt = 1'b1;
    ctl(0, 0, 1, 0, 64'h4);
    step(); step();
    check("stall_pc", CurrentPC, 64'h8);
    check("stall_taken", {63'h0, Taken}, 64'h1);
    check("stall_halted", {63'h0, Halted}, 64'h0);
    check("stall_cnt", {32'h0, BranchCount}, 64'h4);
    Stall = 1'b0;
    step(); check("unstall_pc", CurrentPC, 64'h18);
    check("unstall_taken", {63'h0, Taken}, 64'h1);
    check("unstall_halted", {63'h0, Halted}, 64'h1);
    check("unstall_cnt", {32'h0, BranchCount}, 64'h5);
    Halt = 1'b0;
    ctl(0, 0, 0, 0, 64'h0);
    step(); check("hold_pc", CurrentPC, 64'h18);
    check("hold_taken", {63'h0, Taken}, 64'h0);
    check("hold_npc", NextPC, 64'h18);
    step();
    Resume = 1'b1; Halt = 1'b1;
    step(); check("resume_win_halted", {63'h0, Halted}, 64'h0);
    check("resume_win_pc", CurrentPC, 64'h18);
    Resume = 1'b0; Halt = 1'b0;
    step(); check("post_resume_pc", CurrentPC, 64'h1C);
    Halt = 1'b1;
    step(); check("rehalt_pc", CurrentPC, 64'h20);
    check("rehalt_cnt", {32'h0, BranchCount}, 64'h5);
    Halt = 1'b0;

    // asynchronous reset mid-halt
    #3 resetl = 1'b0;
    #1;
    check("arst_pc", CurrentPC, 64'h0);
    check("arst_halted", {63'h0, Halted}, 64'h0);
    check("arst_cnt", {32'h0, BranchCount}, 64'h0);
    resetl = 1'b1;

    // halt / hold / resume timing
    step(); step(); check("h5_pre_pc", CurrentPC, 64'h8);
    Halt = 1'b1;
    step(); check("h5_halt_pc", CurrentPC, 64'hC);
    check("h5_halted", {63'h0, Halted}, 64'h1);
    Halt = 1'b0;
    step(); step(); step(); check("h5_hold_pc", CurrentPC, 64'hC);
    Resume = 1'b1;
    step(); check("h5_res_halted", {63'h0, Halted}, 64'h0);
    check("h5_res_pc", CurrentPC, 64'hC);
    Resume = 1'b0;
    step(); check("h5_run_pc", CurrentPC, 64'h10);

    // counter saturation on the 2-bit instance
    #2 resetl = 1'b0;
    #1 check("sat_rst", {62'h0, s_cnt}, 64'h0);
    resetl = 1'b1;
    step(); step(); check("sat_cnt2", {62'h0, s_cnt}, 64'h2);
    step(); check("sat_cnt3", {62'h0, s_cnt}, 64'h3);
    step(); step(); check("sat_hold", {62'h0, s_cnt}, 64'h3);
    check("sat_pc", s_pc, 64'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Registered program-counter sequencer for the single-cycle/pipelined ARM-subset datapath.
- Successor to the combinational next-PC logic. It adds:
  - a PC register with a parametrised width and reset vector
  - a CBNZ-style branch mode
  - stall hold
  - a RUN/HALT state machine
  - a saturating taken-branch counter
- Sits between the control unit/ALU zero flag and the instruction memory address port.

Parameters:
- PC_WIDTH, 64, width of PC, immediate and all address arithmetic.
- RESET_PC, 0, value loaded into CurrentPC on reset.
- INSTR_BYTES, 4, sequential increment added to PC.
- IMM_SHIFT, 2, left shift applied to SignExtImm64 before the target add.
- CNT_WIDTH, 32, width of BranchCount.

Ports:
- CLK  input  1  rising-edge clock
- resetl  input  1  asynchronous active-low reset
- SignExtImm64  input  PC_WIDTH  sign-extended branch offset, in instructions
- Branch  input  1  conditional branch, taken when ALUZero=1 (CBZ)
- BranchNZ  input  1  conditional branch, taken when ALUZero=0 (CBNZ)
- Uncondbranch  input  1  unconditional branch
- ALUZero  input  1  ALU zero flag
- Stall  input  1  hold PC and all state this cycle
- Halt  input  1  request halt
- Resume  input  1  leave HALT
- CurrentPC  output  PC_WIDTH  registered PC
- NextPC  output  PC_WIDTH  combinational value CurrentPC will load at the next enabled edge
- Taken  output  1  registered; 1 for the cycle after a committed redirect
- Halted  output  1  registered; 1 while in HALT
- BranchCount  output  CNT_WIDTH  committed taken branches, saturating

Behaviour:
- Reset (resetl=0, asynchronous, any time including mid-halt):
  - CurrentPC=RESET_PC, Taken=0, Halted=0, BranchCount=0, state=RUN.
  - Release is synchronous to the next CLK edge.
- Arithmetic:
  - seq = CurrentPC + INSTR_BYTES.
  - tgt = CurrentPC + (SignExtImm64 << IMM_SHIFT).
  - Both are modulo 2^PC_WIDTH; wrap is silent, no overflow flag.
- Take decision: take = Uncondbranch | (Branch & ALUZero) | (BranchNZ & ~ALUZero).
  - Any simultaneous combination uses this OR.
- NextPC selection:
  - In RUN with take=1: NextPC = tgt.
  - In RUN with take=0: NextPC = seq.
  - In HALT: NextPC = CurrentPC.
- Update enable: en = ~Stall. With Stall=1, every register holds, including the FSM state and Taken. Halt and Resume are ignored during stall.
- FSM, evaluated only when en=1:
  - RUN, Halt=0: CurrentPC<=NextPC. Taken<=take. If take, BranchCount increments, saturating at all-ones.
  - RUN, Halt=1: the instruction at CurrentPC completes. PC updates as above, including any redirect and count. Then state<=HALT and Halted<=1.
  - HALT, Resume=0: hold. Taken<=0.
  - HALT, Resume=1: state<=RUN, Halted<=0. PC does not advance this edge; it advances from the following edge.
  - HALT with Halt and Resume both 1: Resume wins.
- Latency: one edge from inputs to CurrentPC. NextPC has zero latency.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output Misaligned (1 bit, reset 0).
  - In RUN with en=1, if NextPC mod INSTR_BYTES != 0, CurrentPC is not updated and BranchCount is not incremented.
  - On that cycle: state<=HALT, Halted<=1, and Misaligned<=1.
  - Misaligned is sticky until reset. Resume still returns to RUN but does not clear Misaligned.
- When undefined:
  - No Misaligned port.
  - Any NextPC value is loaded unchecked.

Test Plan:
1. Reset, then 3 edges with all controls 0 (RESET_PC=0) -> CurrentPC 0x0, 0x4, 0x8, 0xC; Taken=0; BranchCount=0.
2. CurrentPC=0x10 with Branch=1, ALUZero=1, imm=0x3 -> 0x1C, Taken=1, BranchCount=1. Then BranchNZ=1, ALUZero=1, imm=0x3 -> 0x20, Taken=0.
3. CurrentPC=0x24 with Uncondbranch=1, imm=-1 -> 0x20. CurrentPC=0xFFFF_FFFF_FFFF_FFFC with no branch -> 0x0 (wrap).
4. Stall=1 for 2 cycles with Uncondbranch=1 and Halt=1 -> CurrentPC, Taken, Halted and BranchCount unchanged. On release -> redirect commits and HALT is entered.
5. Halt=1 at PC=0x8 -> PC=0xC and Halted=1. Hold 3 cycles -> PC stays 0xC. Resume=1 -> Halted=0, PC=0xC. Next edge -> PC=0x10.
6. Assert resetl=0 between clock edges while in HALT with BranchCount=5 -> immediately CurrentPC=RESET_PC, Halted=0, BranchCount=0. With PC_ALIGN_CHECK_EN and RESET_PC=0x2 -> first edge gives Misaligned=1, Halted=1, PC=0x2.
